// File: rtl/i8080_regs_pkg.sv
// Shared encodings for the 8080 register-pair datapath.
// Latency: none (types and constants only).
// Backpressure: none.
//
// Holds the pair-index enum, the inc/dec opcode constants and the byte-lane
// mask constants used by reg_pair_file and its bench.
package i8080_regs_pkg;

    // Architectural pair indices; DE and HL form the exchange pair.
    typedef enum logic [1:0] {
        PAIR_BC = 2'd0,
        PAIR_DE = 2'd1,
        PAIR_HL = 2'd2,
        PAIR_SP = 2'd3
    } pair_e;

    // idc_op_i encoding; 2'b11 is treated as no operation.
    localparam logic [1:0] IDC_NONE = 2'b00;
    localparam logic [1:0] IDC_INC  = 2'b01;
    localparam logic [1:0] IDC_DEC  = 2'b10;

    // wr_lane_i encoding; bit0 = low byte lane, bit1 = high byte lane.
    localparam logic [1:0] LANE_LO   = 2'b01;
    localparam logic [1:0] LANE_HI   = 2'b10;
    localparam logic [1:0] LANE_BOTH = 2'b11;

    // True for the two opcodes that actually modify a pair.
    function automatic logic f_idc_active(input logic [1:0] op);
        return (op == IDC_INC) || (op == IDC_DEC);
    endfunction

endpackage

// File: rtl/reg_pair_incdec.sv
// Combinational WIDTH-bit increment/decrement with wrap detection.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
//
// Ports:
//   i_val  [WIDTH-1:0]  operand
//   i_dec               1 = decrement, 0 = increment
//   o_val  [WIDTH-1:0]  i_val +/- 1 modulo 2^WIDTH
//   o_wrap              increment of all-ones or decrement of zero
module reg_pair_incdec #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_val,
    input  logic             i_dec,
    output logic [WIDTH-1:0] o_val,
    output logic             o_wrap
);

    always_comb begin
        o_val  = i_val;
        o_wrap = 1'b0;
        if (i_dec) begin
            o_val  = i_val - WIDTH'(1);
            o_wrap = (i_val == '0);
        end else begin
            o_val  = i_val + WIDTH'(1);
            o_wrap = (i_val == '1);
        end
    end

endmodule

// File: rtl/reg_pair_file.sv
// 8080 register-pair file: byte-lane writes, single-port inc/dec, DE<->HL exchange.
// Latency: updates visible 1 cycle after the edge; read is combinational.
// Backpressure: none; every request is single-cycle and always accepted.
//
// Build option: REG_PAIR_BYPASS_EN enables same-cycle read-after-write bypass.
//
// Ports:
//   clk50M_i, rst_ni              clock (rising edge), async active-low reset
//   rd_en_i, rd_sel_i, data_q     read port; data_q is 'z when rd_en_i=0
//   wr_en_i, wr_sel_i, wr_lane_i,
//   data_d                        lane-masked write port
//   idc_op_i, idc_sel_i           increment/decrement port
//   xchg_i                        swap pairs 1 (DE) and 2 (HL)
//   wrap_o                        registered wrap pulse from an executed inc/dec
module reg_pair_file
    import i8080_regs_pkg::*;
#(
    parameter  int unsigned      WIDTH     = 16,
    parameter  int unsigned      NPAIRS    = 4,
    parameter  logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int unsigned      SELW      = $clog2(NPAIRS)
) (
    input  logic             clk50M_i,
    input  logic             rst_ni,
    input  logic             rd_en_i,
    input  logic [SELW-1:0]  rd_sel_i,
    output logic [WIDTH-1:0] data_q,
    input  logic             wr_en_i,
    input  logic [SELW-1:0]  wr_sel_i,
    input  logic [1:0]       wr_lane_i,
    input  logic [WIDTH-1:0] data_d,
    input  logic [1:0]       idc_op_i,
    input  logic [SELW-1:0]  idc_sel_i,
    input  logic             xchg_i,
    output logic             wrap_o
);

    localparam int unsigned HALF = WIDTH / 2;
    localparam int unsigned NSEL = 1 << SELW;
    localparam int unsigned XA   = PAIR_DE;
    localparam int unsigned XB   = PAIR_HL;

    // One bit per encodable select value: set when that index names a real
    // pair. Indexing this mask avoids range compares that fold to constants
    // when NPAIRS is a power of two.
    function automatic logic [NSEL-1:0] f_valid_mask();
        logic [NSEL-1:0] m;
        m = '0;
        for (int i = 0; i < int'(NSEL); i++) begin
            m[i] = (i < int'(NPAIRS));
        end
        return m;
    endfunction

    localparam logic [NSEL-1:0] VALID = f_valid_mask();

    logic [WIDTH-1:0] r_pair     [NPAIRS];
    logic             r_wrap;

    logic [WIDTH-1:0] w_nxt      [NPAIRS];
    logic [WIDTH-1:0] w_pair_ext [NSEL];
    logic [WIDTH-1:0] w_idc_src;
    logic [WIDTH-1:0] w_idc_res;
    logic             w_idc_wrap;
    logic             w_idc_dec;
    logic             w_wr_any;
    logic             w_collide;
    logic             w_idc_go;
    logic             w_wrap_nxt;
    logic [WIDTH-1:0] w_rd_val;

    // Pad the pair array out to every encodable index; unused slots read as
    // zero, which is exactly the out-of-range read value.
    for (genvar g = 0; g < int'(NSEL); g++) begin : g_ext
        if (g < int'(NPAIRS)) begin : g_real
            assign w_pair_ext[g] = r_pair[g];
        end else begin : g_pad
            assign w_pair_ext[g] = '0;
        end
    end

    // Single shared inc/dec unit, fed by the idc_sel_i mux.
    assign w_idc_src = w_pair_ext[idc_sel_i];
    assign w_idc_dec = (idc_op_i == IDC_DEC);

    reg_pair_incdec #(
        .WIDTH (WIDTH)
    ) u_incdec (
        .i_val  (w_idc_src),
        .i_dec  (w_idc_dec),
        .o_val  (w_idc_res),
        .o_wrap (w_idc_wrap)
    );

    // A write with an empty lane mask does not collide with inc/dec; any
    // non-empty write to the same pair suppresses inc/dec and its wrap flag.
    assign w_wr_any  = wr_en_i && (wr_lane_i != 2'b00);
    assign w_collide = w_wr_any && (wr_sel_i == idc_sel_i);
    assign w_idc_go  = !xchg_i && f_idc_active(idc_op_i)
                       && VALID[idc_sel_i] && !w_collide;
    assign w_wrap_nxt = w_idc_go && w_idc_wrap;

    // Next state: exchange or inc/dec first, then the lane write on top.
    always_comb begin
        w_nxt = r_pair;

        if (xchg_i) begin
            w_nxt[XA] = r_pair[XB];
            w_nxt[XB] = r_pair[XA];
        end

        for (int i = 0; i < int'(NPAIRS); i++) begin
            if (w_idc_go && (idc_sel_i == SELW'(i))) begin
                w_nxt[i] = w_idc_res;
            end
        end

        for (int i = 0; i < int'(NPAIRS); i++) begin
            if (wr_en_i && (wr_sel_i == SELW'(i))) begin
                if ((wr_lane_i & LANE_LO) != 2'b00) begin
                    w_nxt[i][HALF-1:0] = data_d[HALF-1:0];
                end
                if ((wr_lane_i & LANE_HI) != 2'b00) begin
                    w_nxt[i][WIDTH-1:HALF] = data_d[WIDTH-1:HALF];
                end
            end
        end
    end

    always_ff @(posedge clk50M_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NPAIRS); i++) begin
                r_pair[i] <= RESET_VAL;
            end
            r_wrap <= 1'b0;
        end else begin
            r_pair <= w_nxt;
            r_wrap <= w_wrap_nxt;
        end
    end

    assign wrap_o = r_wrap;

    // Read mux. With the bypass built in, a same-index write is merged into
    // the stored value by lane; inc/dec and exchange are not forwarded.
    always_comb begin
        w_rd_val = w_pair_ext[rd_sel_i];
`ifdef REG_PAIR_BYPASS_EN
        if (wr_en_i && VALID[wr_sel_i] && (wr_sel_i == rd_sel_i)) begin
            if ((wr_lane_i & LANE_LO) != 2'b00) begin
                w_rd_val[HALF-1:0] = data_d[HALF-1:0];
            end
            if ((wr_lane_i & LANE_HI) != 2'b00) begin
                w_rd_val[WIDTH-1:HALF] = data_d[WIDTH-1:HALF];
            end
        end
`endif
    end

    assign data_q = rd_en_i ? w_rd_val : {WIDTH{1'bz}};

endmodule
